dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the byte-addressed data memory (4096 x 8, combinational read/write, length codes 00=word, 01=byte, 10=half).
- Shares the memory between the CPU memory stage and a DMA/debug requester.
- Each requester uses a req/ack handshake; the arbiter drives the memory strobes for exactly one cycle per access and returns registered read data.
- Rejects illegal accesses (bad length, misaligned, out of range) without touching memory.

---
 rtl/dmem_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 4096 x 8 data memory.
// The CPU memory stage and a DMA/debug requester share the memory through
// req/ack handshakes; each legal access drives the memory strobes for one
// cycle and returns registered read data one cycle later with the ack.
// Illegal requests (bad length, misaligned, out of range) never reach memory.
// Optional build macro: DMEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority
// instead of round-robin arbitration.
module dmem_arbiter #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpureq,
  input  logic        cpuwe,
  input  logic [31:0] cpuaddr,
  input  logic [31:0] cpuwdata,
  input  logic [1:0]  cpulength,
  input  logic        cpusign,
  output logic        cpuack,
  output logic [31:0] cpurdata,
  output logic        cpuerr,
  input  logic        dmareq,
  input  logic        dmawe,
  input  logic [31:0] dmaaddr,
  input  logic [31:0] dmawdata,
  input  logic [1:0]  dmalength,
  input  logic        dmasign,
  output logic        dmaack,
  output logic [31:0] dmardata,
  output logic        dmaerr,
  output logic [31:0] memaddress,
  output logic [31:0] memwdata,
  output logic        memread,
  output logic        memwrite,
  output logic [1:0]  memlength,
  output logic        memsign,
  input  logic [31:0] memrdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t      state_q, state_d;

  logic        grantDma_q;
  logic        err_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;
  logic [1:0]  memLength_q;
  logic        memSign_q;

  logic        anyReq;
  logic        pickDma;
  logic        grantNow;
  logic        selWe;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic [1:0]  selLength;
  logic        selSign;
  logic [2:0]  selSize;
  logic [32:0] selEnd;
  logic        selIllegal;

  assign anyReq   = cpureq | dmareq;
  assign grantNow = (state_q == IDLE) && anyReq;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  // Fixed priority: DMA is only chosen when the CPU is not requesting.
  always_comb begin
    pickDma = ~cpureq;
  end
`else
  logic lastDma_q;

  // Round-robin choice: on contention the port that did not win last time goes.
  always_comb begin
    pickDma = dmareq & (~cpureq | ~lastDma_q);
  end

  // Remember the last winner; reset pretends DMA went last so the CPU goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastDma_q <= 1'b1;
    end else if (grantNow) begin
      lastDma_q <= pickDma;
    end
  end
`endif

  // Steer the winning port's request fields onto one set of wires.
  always_comb begin
    selWe     = pickDma ? dmawe     : cpuwe;
    selAddr   = pickDma ? dmaaddr   : cpuaddr;
    selWdata  = pickDma ? dmawdata  : cpuwdata;
    selLength = pickDma ? dmalength : cpulength;
    selSign   = pickDma ? dmasign   : cpusign;
  end

  // Legality check: length code, alignment, and the last byte touched must
  // fall inside both the AW-bit decode window and the populated DEPTH.
  always_comb begin
    selIllegal = 1'b0;
    case (selLength)
      2'b00:   selSize = 3'd4;
      2'b01:   selSize = 3'd1;
      2'b10:   selSize = 3'd2;
      default: selSize = 3'd1;
    endcase
    selEnd = {1'b0, selAddr} + {30'd0, selSize} - 33'd1;
    if (selLength == 2'b11) begin
      selIllegal = 1'b1;
    end
    if ((selLength == 2'b00) && (selAddr[1:0] != 2'b00)) begin
      selIllegal = 1'b1;
    end
    if ((selLength == 2'b10) && selAddr[0]) begin
      selIllegal = 1'b1;
    end
    if (((selEnd >> AW) != 33'd0) || (selEnd >= 33'(DEPTH))) begin
      selIllegal = 1'b1;
    end
  end

  // Sequencer next state: illegal requests skip the memory cycle entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d = selIllegal ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset mid-access abandons the transaction without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the grant, its direction and its verdict when a request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantDma_q <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
    end else if (grantNow) begin
      grantDma_q <= pickDma;
      err_q      <= selIllegal;
      we_q       <= selWe;
    end
  end

  // Memory-side fields change only for legal grants so they hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memAddr_q   <= 32'd0;
      memWdata_q  <= 32'd0;
      memLength_q <= 2'b00;
      memSign_q   <= 1'b0;
    end else if (grantNow && !selIllegal) begin
      memAddr_q   <= selAddr;
      memWdata_q  <= selWdata;
      memLength_q <= selLength;
      memSign_q   <= selSign;
    end
  end

  // Response data: cleared at grant, filled from memory at the end of a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (grantNow) begin
      rdata_q <= 32'd0;
    end else if (state_q == ACCESS) begin
      rdata_q <= we_q ? 32'd0 : memrdata;
    end
  end

  // Output decode straight from the state register so reset drops strobes at once.
  always_comb begin
    memread    = (state_q == ACCESS) && !we_q;
    memwrite   = (state_q == ACCESS) && we_q;
    memaddress = memAddr_q;
    memwdata   = memWdata_q;
    memlength  = memLength_q;
    memsign    = memSign_q;
    busy       = (state_q != IDLE);
    cpuack     = (state_q == RESP) && !grantDma_q;
    dmaack     = (state_q == RESP) && grantDma_q;
    cpuerr     = cpuack && err_q;
    dmaerr     = dmaack && err_q;
    cpurdata   = cpuack ? rdata_q : 32'd0;
    dmardata   = dmaack ? rdata_q : 32'd0;
  end

endmodule
